// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer for the LEGv8 core: latches ELR/ESR, redirects
// fetch to the handler vector, masks nesting, returns on ERET, halts on double fault.
module exc_sequencer #(
  parameter int unsigned   N      = 64,
  parameter logic [N-1:0]  VECTOR = 'h0000_00D8,
  parameter int unsigned   CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             not_an_instr,
  input  logic             eret,
  input  logic             ext_irq,
  input  logic             irq_en,
  input  logic [N-1:0]     pc,
  output logic             redirect,
  output logic [N-1:0]     redirect_pc,
  output logic             exc_ack,
  output logic             ext_iack,
  output logic             in_handler,
  output logic             stall,
  output logic [N-1:0]     elr,
  output logic [3:0]       esr,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic [2:0] {
    S_RUN,
    S_ENTER,
    S_HANDLER,
    S_RETURN,
    S_HALT
  } state_t;

  localparam logic [3:0] ESR_NONE  = 4'b0000;
  localparam logic [3:0] ESR_IRQ   = 4'b0001;
  localparam logic [3:0] ESR_UNDEF = 4'b0010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   take_undef;
  logic   take_irq;

  // ERET seen outside a handler is treated as an undefined instruction.
  always_comb begin
    take_undef = not_an_instr | eret;
    take_irq   = ext_irq & irq_en;
  end

  // Outputs are registered alongside the state they belong to, so each is
  // loaded on the edge that enters the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      exc_ack     <= 1'b0;
      ext_iack    <= 1'b0;
      in_handler  <= 1'b0;
      stall       <= 1'b0;
      elr         <= '0;
      esr         <= ESR_NONE;
      exc_count   <= '0;
    end else begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      exc_ack     <= 1'b0;
      ext_iack    <= 1'b0;
      in_handler  <= 1'b0;
      stall       <= 1'b0;
      case (state)
        S_RUN: begin
          if (take_undef || take_irq) begin
            state       <= S_ENTER;
            elr         <= pc;
            esr         <= take_undef ? ESR_UNDEF : ESR_IRQ;
            redirect    <= 1'b1;
            redirect_pc <= VECTOR;
            exc_ack     <= 1'b1;
            ext_iack    <= ~take_undef;
            in_handler  <= 1'b1;
            if (exc_count != '1)
              exc_count <= exc_count + CNT_ONE;
          end
        end
        S_ENTER: begin
          state      <= S_HANDLER;
          in_handler <= 1'b1;
        end
        S_HANDLER: begin
          if (eret) begin
            state       <= S_RETURN;
            redirect    <= 1'b1;
            redirect_pc <= elr;
            esr         <= ESR_NONE;
          end else if (not_an_instr) begin
            state <= S_HALT;
            stall <= 1'b1;
          end else begin
            in_handler <= 1'b1;
          end
        end
        S_RETURN: begin
          state <= S_RUN;
        end
        S_HALT: begin
          stall <= 1'b1;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: a per-cycle vector table plus hand-written
// sequences for halt hold, reset in ENTER and counter saturation.
module tb_exc_sequencer;

  logic        clk;
  logic        reset;
  logic        not_an_instr;
  logic        eret;
  logic        ext_irq;
  logic        irq_en;
  logic [63:0] pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        exc_ack;
  logic        ext_iack;
  logic        in_handler;
  logic        stall;
  logic [63:0] elr;
  logic [3:0]  esr;
  logic [7:0]  exc_count;

  int checks = 0;
  int errors = 0;

  exc_sequencer #(
    .N(64),
    .VECTOR(64'h0000_00D8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .not_an_instr(not_an_instr),
    .eret(eret),
    .ext_irq(ext_irq),
    .irq_en(irq_en),
    .pc(pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .exc_ack(exc_ack),
    .ext_iack(ext_iack),
    .in_handler(in_handler),
    .stall(stall),
    .elr(elr),
    .esr(esr),
    .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {reset, not_an_instr, eret, ext_irq, irq_en}
  // fl = {redirect, exc_ack, ext_iack, in_handler, stall}, expected after the edge
  typedef struct {
    logic [4:0]  in;
    logic [63:0] pc;
    logic [4:0]  fl;
    logic [63:0] rpc;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [4:0] in, input logic [63:0] p);
    @(negedge clk);
    {reset, not_an_instr, eret, ext_irq, irq_en} = in;
    pc = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [4:0] fl, input logic [63:0] rpc,
                           input logic [63:0] e, input logic [3:0] s, input logic [7:0] c);
    chk({tag, " redirect"},    {63'd0, redirect},   {63'd0, fl[4]});
    chk({tag, " exc_ack"},     {63'd0, exc_ack},    {63'd0, fl[3]});
    chk({tag, " ext_iack"},    {63'd0, ext_iack},   {63'd0, fl[2]});
    chk({tag, " in_handler"},  {63'd0, in_handler}, {63'd0, fl[1]});
    chk({tag, " stall"},       {63'd0, stall},      {63'd0, fl[0]});
    chk({tag, " redirect_pc"}, redirect_pc, rpc);
    chk({tag, " elr"},         elr, e);
    chk({tag, " esr"},         {60'd0, esr}, {60'd0, s});
    chk({tag, " exc_count"},   {56'd0, exc_count}, {56'd0, c});
  endtask

  initial begin
    reset = 1'b0; not_an_instr = 1'b0; eret = 1'b0; ext_irq = 1'b0; irq_en = 1'b0; pc = '0;

    vecs[0]  = '{5'b10000, 64'h000, 5'b00000, 64'h000, 64'h000, 4'h0, 8'd0};
    vecs[1]  = '{5'b01000, 64'h040, 5'b11010, 64'h0D8, 64'h040, 4'h2, 8'd1};
    vecs[2]  = '{5'b01011, 64'h099, 5'b00010, 64'h000, 64'h040, 4'h2, 8'd1};
    vecs[3]  = '{5'b00011, 64'h044, 5'b00010, 64'h000, 64'h040, 4'h2, 8'd1};
    vecs[4]  = '{5'b00100, 64'h048, 5'b10000, 64'h040, 64'h040, 4'h0, 8'd1};
    vecs[5]  = '{5'b01000, 64'h04C, 5'b00000, 64'h000, 64'h040, 4'h0, 8'd1};
    vecs[6]  = '{5'b00010, 64'h080, 5'b00000, 64'h000, 64'h040, 4'h0, 8'd1};
    vecs[7]  = '{5'b00011, 64'h100, 5'b11110, 64'h0D8, 64'h100, 4'h1, 8'd2};
    vecs[8]  = '{5'b00000, 64'h0D8, 5'b00010, 64'h000, 64'h100, 4'h1, 8'd2};
    vecs[9]  = '{5'b00100, 64'h0DC, 5'b10000, 64'h100, 64'h100, 4'h0, 8'd2};
    vecs[10] = '{5'b00000, 64'h100, 5'b00000, 64'h000, 64'h100, 4'h0, 8'd2};
    vecs[11] = '{5'b01011, 64'h200, 5'b11010, 64'h0D8, 64'h200, 4'h2, 8'd3};
    vecs[12] = '{5'b00011, 64'h0D8, 5'b00010, 64'h000, 64'h200, 4'h2, 8'd3};
    vecs[13] = '{5'b00111, 64'h0DC, 5'b10000, 64'h200, 64'h200, 4'h0, 8'd3};
    vecs[14] = '{5'b00011, 64'h204, 5'b00000, 64'h000, 64'h200, 4'h0, 8'd3};
    vecs[15] = '{5'b00011, 64'h204, 5'b11110, 64'h0D8, 64'h204, 4'h1, 8'd4};
    vecs[16] = '{5'b00000, 64'h0D8, 5'b00010, 64'h000, 64'h204, 4'h1, 8'd4};
    vecs[17] = '{5'b00100, 64'h0DC, 5'b10000, 64'h204, 64'h204, 4'h0, 8'd4};
    vecs[18] = '{5'b00000, 64'h204, 5'b00000, 64'h000, 64'h204, 4'h0, 8'd4};
    vecs[19] = '{5'b00100, 64'h300, 5'b11010, 64'h0D8, 64'h300, 4'h2, 8'd5};
    vecs[20] = '{5'b00000, 64'h0D8, 5'b00010, 64'h000, 64'h300, 4'h2, 8'd5};
    vecs[21] = '{5'b01000, 64'h0DC, 5'b00001, 64'h000, 64'h300, 4'h2, 8'd5};

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].in, vecs[i].pc);
      check_all($sformatf("vec%0d", i), vecs[i].fl, vecs[i].rpc, vecs[i].elr,
                vecs[i].esr, vecs[i].cnt);
    end

    // HALT absorbs everything except reset
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 5'b01111 : 5'b00111, 64'h400);
      check_all($sformatf("halt%0d", i), 5'b00001, 64'h0, 64'h300, 4'h2, 8'd5);
    end
    step(5'b10000, 64'h0);
    check_all("halt_reset", 5'b00000, 64'h0, 64'h0, 4'h0, 8'd0);

    // Reset landing in ENTER must cancel the pending iack
    step(5'b00011, 64'h500);
    check_all("pre_reset_enter", 5'b11110, 64'h0D8, 64'h500, 4'h1, 8'd1);
    step(5'b10011, 64'h504);
    check_all("reset_in_enter", 5'b00000, 64'h0, 64'h0, 4'h0, 8'd0);
    step(5'b00000, 64'h508);
    check_all("after_reset_enter", 5'b00000, 64'h0, 64'h0, 4'h0, 8'd0);

    // Counter saturation over 260 exceptions
    for (int i = 1; i <= 260; i++) begin
      step(5'b01000, 64'h1000);
      chk($sformatf("sat_cnt%0d", i), {56'd0, exc_count}, (i > 255) ? 64'd255 : 64'(i));
      step(5'b00000, 64'h0D8);
      step(5'b00100, 64'h0DC);
      step(5'b00000, 64'h1000);
    end
    check_all("sat_final", 5'b00000, 64'h0, 64'h1000, 4'h0, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
